// File: rtl/reg_preload_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_preload_pkg
// Description : Shared types and constants for the register-file preloader.
//               Holds the loader state encoding, the number of registers
//               loaded per sequence and the output reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_preload_pkg;

    // Registers seeded by one load sequence (r0..r31).
    localparam int NUM_REGS = 32;

    // CHECK stays in the encoding even when the checksum stage is not built,
    // so the state width and values never change between build variants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Output values while in reset / IDLE.
    localparam logic c_rst_in_ready = 1'b0;
    localparam logic c_rst_cpu_hold = 1'b0;
    localparam logic c_rst_busy     = 1'b0;
    localparam logic c_rst_done     = 1'b0;
    localparam logic c_rst_err      = 1'b0;

endpackage : reg_preload_pkg
`default_nettype wire

// File: rtl/preload_wport_mux.sv
`default_nettype none
// ============================================================================
// Module      : preload_wport_mux
// Description : Combinational selector for the regfile write port. While the
//               loader is active the processor's write port is shut out
//               entirely and the loader's port drives the regfile; otherwise
//               the processor port passes straight through.
// Ports       : i_sel_loader            1 = loader owns the write port
//               i_cpu_we/wreg/wdata     processor write port
//               i_ld_we/wreg/wdata      loader write port
//               o_we/o_wreg/o_wdata     to the regfile
// Revision    : 1.0 - initial release
// ============================================================================
module preload_wport_mux #(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_sel_loader,
    input  logic              i_cpu_we,
    input  logic [IDX_W-1:0]  i_cpu_wreg,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic              i_ld_we,
    input  logic [IDX_W-1:0]  i_ld_wreg,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_we,
    output logic [IDX_W-1:0]  o_wreg,
    output logic [DATA_W-1:0] o_wdata
);

    always_comb begin
        if (i_sel_loader) begin
            o_we    = i_ld_we;
            o_wreg  = i_ld_wreg;
            o_wdata = i_ld_wdata;
        end else begin
            o_we    = i_cpu_we;
            o_wreg  = i_cpu_wreg;
            o_wdata = i_cpu_wdata;
        end
    end

endmodule : preload_wport_mux
`default_nettype wire

// File: rtl/reg_preloader.sv
`default_nettype none
// ============================================================================
// Module      : reg_preloader
// Description : Register-file preloader. A start pulse in IDLE stalls the
//               processor, accepts NUM_REGS words over a valid/ready stream
//               and writes word k into register k (word 0 is consumed but r0
//               is never written), then pulses done and releases the
//               processor. Outside a sequence the processor write port passes
//               through untouched.
// Build option: PRELOAD_CHECKSUM_EN - when defined, one extra stream word is
//               accepted after the last register and compared against the
//               32-bit wrapping sum of all loaded words; a mismatch sets the
//               sticky err flag (cleared by the next start).
// Ports       : clock, reset (async, active low)
//               start                       begin a sequence (IDLE only)
//               in_valid/in_data/in_ready   load stream
//               cpu_we/cpu_wreg/cpu_wdata   processor write port
//               ctrl_writeEnable/ctrl_writeReg/data_writeReg  regfile port
//               cpu_hold, busy, done, err   status
// Revision    : 1.0 - initial release
// ============================================================================
module reg_preloader #(
    parameter int NUM_REGS = reg_preload_pkg::NUM_REGS,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_we,
    input  logic [IDX_W-1:0]  cpu_wreg,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              ctrl_writeEnable,
    output logic [IDX_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import reg_preload_pkg::*;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REGS - 1);

`ifdef PRELOAD_CHECKSUM_EN
    localparam state_t c_after_load = CHECK;
`else
    localparam state_t c_after_load = DONE;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             w_start_seq;
    logic             w_load_hs;
    logic             w_ld_we;

    // Starting a sequence and accepting a LOAD word only depend on state
    // and the request inputs, never on in_ready, so status outputs stay a
    // pure decode of registered state.
    assign w_start_seq = (r_state == IDLE) && start;
    assign w_load_hs   = (r_state == LOAD) && in_valid;
    // Word 0 is drained from the stream but r0 stays untouched.
    assign w_ld_we     = w_load_hs && (r_idx != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = c_rst_in_ready;
        cpu_hold    = c_rst_cpu_hold;
        busy        = c_rst_busy;
        done        = c_rst_done;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                // Leave on the last word, before idx wraps back to 0.
                if (in_valid && (r_idx == c_last_idx)) begin
                    w_state_nxt = c_after_load;
                end
            end
`ifdef PRELOAD_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                done        = 1'b1;
                cpu_hold    = 1'b1;
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register index
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_start_seq) begin
            r_idx <= '0;
        end else if (w_load_hs) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum stage
    // ------------------------------------------------------------------
`ifdef PRELOAD_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_err;
    logic [31:0] w_word32;

    assign w_word32 = 32'(in_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
            r_err <= c_rst_err;
        end else if (w_start_seq) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_load_hs) begin
                r_sum <= r_sum + w_word32;
            end
            // Sticky: only a new start clears it.
            if ((r_state == CHECK) && in_valid && (w_word32 != r_sum)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = c_rst_err;
`endif

    // ------------------------------------------------------------------
    // Regfile write-port selection. busy covers DONE as well, so a
    // processor write issued while held is dropped rather than replayed.
    // ------------------------------------------------------------------
    preload_wport_mux #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_wport_mux (
        .i_sel_loader (busy),
        .i_cpu_we     (cpu_we),
        .i_cpu_wreg   (cpu_wreg),
        .i_cpu_wdata  (cpu_wdata),
        .i_ld_we      (w_ld_we),
        .i_ld_wreg    (r_idx),
        .i_ld_wdata   (in_data),
        .o_we         (ctrl_writeEnable),
        .o_wreg       (ctrl_writeReg),
        .o_wdata      (data_writeReg)
    );

endmodule : reg_preloader
`default_nettype wire

// File: tb/tb_reg_preloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_preloader
// Description : Self-checking bench for reg_preloader. A behavioural regfile
//               captures the write port; a cycle-level acceptance model
//               (count of accepted words, ready while loading and fewer than
//               the expected number of words taken) predicts in_ready, busy,
//               cpu_hold, done timing and final register contents.
//               Honours PRELOAD_CHECKSUM_EN (extra checksum word, err flag).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_preloader;

`ifdef PRELOAD_CHECKSUM_EN
    localparam bit c_chk = 1'b1;
`else
    localparam bit c_chk = 1'b0;
`endif
    localparam int c_nwords = c_chk ? 33 : 32;
    localparam int c_max_cyc = 400;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        cpu_we;
    logic [4:0]  cpu_wreg;
    logic [31:0] cpu_wdata;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    reg_preloader dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .cpu_we           (cpu_we),
        .cpu_wreg         (cpu_wreg),
        .cpu_wdata        (cpu_wdata),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .cpu_hold         (cpu_hold),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural regfile on the write port.
    logic [31:0] rf [32];
    logic        rf_clr;
    int          zero_wr_cnt = 0;

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (ctrl_writeEnable) begin
            rf[ctrl_writeReg] <= data_writeReg;
            if (ctrl_writeReg == 5'd0) zero_wr_cnt <= zero_wr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_rf();
        @(posedge clock); #1 rf_clr = 1'b1;
        @(posedge clock); #1 rf_clr = 1'b0;
    endtask

    function automatic logic vpat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One complete load sequence. kind: 0 -> word k = k*mult, 1 -> k+1,
    // 2 -> random. exp_done 0 means "use the model's done cycle".
    // inject re-pulses start and issues a processor write during LOAD.
    task automatic run_seq(input string name, input int mode, input int kind, input int mult,
                           input bit bad_sum, input int exp_done, input bit inject, input bit clr);
        logic [31:0] words [33];
        logic [31:0] sum;
        int ptr, c, fin_c, done_c, ready_bad, hold_bad, done_bad, bad_regs, zw0;
        bit exp_ready, exp_busy;

        sum = '0;
        for (int k = 0; k < 32; k++) begin
            case (kind)
                0:       words[k] = 32'(k * mult);
                1:       words[k] = 32'(k + 1);
                default: words[k] = $urandom;
            endcase
            sum = sum + words[k];
        end
        words[32] = bad_sum ? sum - 32'd1 : sum;

        if (clr) clear_rf();
        zw0 = zero_wr_cnt;

        @(posedge clock); #1;
        start = 1'b1; in_valid = vpat(mode, 0); in_data = words[0];
        ptr = 0; c = 0; fin_c = 1000; done_c = -1;
        ready_bad = 0; hold_bad = 0; done_bad = 0;

        while (c <= fin_c + 1 && c < c_max_cyc) begin
            @(negedge clock);
            exp_ready = (c >= 1) && (ptr < c_nwords);
            exp_busy  = (c >= 1) && (c <= fin_c);
            if (in_ready !== exp_ready) ready_bad++;
            if (busy !== exp_busy || cpu_hold !== exp_busy) hold_bad++;
            if (done !== (c == fin_c)) done_bad++;
            if (done === 1'b1 && done_c < 0) done_c = c;
            @(posedge clock);
            if (in_valid && exp_ready) begin
                ptr++;
                if (ptr == c_nwords) fin_c = c + 1;
            end
            c++;
            #1;
            start     = inject && (c >= 5) && (c <= 8);
            in_valid  = vpat(mode, c);
            in_data   = (ptr < 33) ? words[ptr] : $urandom;
            cpu_we    = inject && (c >= 10) && (c <= 13);
            cpu_wreg  = 5'd3;
            cpu_wdata = 32'hDEAD_BEEF;
        end
        in_valid = 1'b0; cpu_we = 1'b0; start = 1'b0;

        check({name, ":no_timeout"}, 64'(c >= c_max_cyc), 64'd0);
        check({name, ":done_cycle"}, 64'(done_c), 64'((exp_done != 0) ? exp_done : fin_c));
        check({name, ":in_ready_trace"}, 64'(ready_bad), 64'd0);
        check({name, ":busy_hold_trace"}, 64'(hold_bad), 64'd0);
        check({name, ":done_pulse_trace"}, 64'(done_bad), 64'd0);
        check({name, ":err"}, 64'(err), 64'(c_chk && bad_sum));
        @(posedge clock); #1;
        check({name, ":r0_writes"}, 64'(zero_wr_cnt - zw0), 64'd0);
        bad_regs = (rf[0] !== 32'd0) ? 1 : 0;
        for (int k = 1; k < 32; k++) if (rf[k] !== words[k]) bad_regs++;
        check({name, ":regs"}, 64'(bad_regs), 64'd0);
        if (inject) check({name, ":r3_after_cpu_write"}, 64'(rf[3]), 64'(words[3]));
    endtask

    typedef struct {
        string name;
        int    mode;
        int    kind;
        int    mult;
        bit    bad_sum;
        int    done_plain;
        int    done_chk;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"const_x3",   0, 0, 3, 1'b0, 33, 34};
        vecs[1] = '{"toggle_x3",  1, 0, 3, 1'b0, 64, 66};
        vecs[2] = '{"seq_good",   0, 1, 0, 1'b0, 33, 34};
        vecs[3] = '{"seq_badsum", 0, 1, 0, 1'b1, 33, 34};
        vecs[4] = '{"rand_a",     2, 2, 0, 1'b0, 0,  0};
        vecs[5] = '{"rand_bad",   2, 2, 0, 1'b1, 0,  0};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cpu_we = 1'b0; cpu_wreg = '0; cpu_wdata = '0; rf_clr = 1'b0;

        // Reset values, with the write port passing through during reset.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst:in_ready", 64'(in_ready), 64'd0);
        check("rst:cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:err", 64'(err), 64'd0);
        cpu_we = 1'b1; cpu_wreg = 5'd9;
        #1 check("rst:we_passthru", 64'({ctrl_writeEnable, ctrl_writeReg}), 64'({1'b1, 5'd9}));
        cpu_we = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        clear_rf();

        // Processor write passes through in IDLE.
        cpu_we = 1'b1; cpu_wreg = 5'd7; cpu_wdata = 32'd5;
        @(negedge clock);
        check("cpu:hold_low", 64'(cpu_hold), 64'd0);
        @(posedge clock); #1 cpu_we = 1'b0;
        check("cpu:r7", 64'(rf[7]), 64'd5);

        for (int i = 0; i < 6; i++)
            run_seq(vecs[i].name, vecs[i].mode, vecs[i].kind, vecs[i].mult, vecs[i].bad_sum,
                    c_chk ? vecs[i].done_chk : vecs[i].done_plain, 1'b0, 1'b1);

        // start re-pulsed and processor write issued during LOAD.
        run_seq("ignore", 0, 0, 7, 1'b0, c_chk ? 34 : 33, 1'b1, 1'b1);

        // Reset mid-sequence after 10 handshakes, then a full reload.
        clear_rf();
        @(posedge clock); #1 start = 1'b1; in_valid = 1'b1; in_data = 32'd0;
        @(posedge clock); #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1 in_data = 32'(k * 11);
        end
        #2 reset = 1'b0;
        #1;
        check("abort:busy", 64'(busy), 64'd0);
        check("abort:cpu_hold", 64'(cpu_hold), 64'd0);
        check("abort:in_ready", 64'(in_ready), 64'd0);
        check("abort:partial_r9", 64'(rf[9]), 64'd99);
        in_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        run_seq("reload", 0, 0, 5, 1'b0, c_chk ? 34 : 33, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_reg_preloader
`default_nettype wire
